// File: rtl/ascon_host_ctrl.sv
// ascon_host_ctrl
// Hardware initiator for ascon_top. It latches key/nonce/AD on an accepted
// go_i and starts the core. It then feeds one AD block and NB_PT plaintext
// blocks, pacing each step on the core's end flags. Each ciphertext block and
// the final tag are returned to the host.
//
// Configuration macro: ASCON_HOST_TIMEOUT_EN
//   defined   : watchdog on W_INIT/W_AD/W_CT; expiry after TIMEOUT cycles -> ERR
//   undefined : no watchdog, waits forever, error_o tied 0
//
// Ports
//   clock_i, reset_i          clock (rising edge), async active-high reset
//   go_i                      begin message (ignored while busy_o)
//   key_i/nonce_i/ad_i        message inputs, sampled on accepted go_i
//   pt_valid_i/pt_i/pt_ready_o host plaintext stream
//   ct_valid_o/ct_o           ciphertext block out (1-cycle pulse, value held)
//   tag_valid_o/tag_o         tag out (pulse together with done_o)
//   busy_o/done_o/error_o     status
//   start_o/key_o/nonce_o/data_o/data_valid_o   towards core
//   end_init_i/end_associated_i/end_cipher_i/end_i/cipher_valid_i/cipher_i/tag_i  from core
//
// States
//   IDLE   | waiting for go_i
//   START  | start_o pulse to core
//   W_INIT | waiting for end_init_i
//   S_AD   | data_valid_o pulse with AD block
//   W_AD   | waiting for end_associated_i
//   W_PT   | pt_ready_o high, waiting for host plaintext
//   S_PT   | data_valid_o pulse with plaintext block
//   W_CT   | waiting for end_cipher_i (or end_i on the last block)
//   DONE   | done_o / tag_valid_o pulse
//   ERR    | watchdog fired, waiting for go_i
module ascon_host_ctrl #(
  parameter int NB_PT   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         go_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] ad_i,
  input  logic         pt_valid_i,
  input  logic [127:0] pt_i,
  output logic         pt_ready_o,
  output logic         ct_valid_o,
  output logic [127:0] ct_o,
  output logic         tag_valid_o,
  output logic [127:0] tag_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic         start_o,
  output logic [127:0] key_o,
  output logic [127:0] nonce_o,
  output logic [127:0] data_o,
  output logic         data_valid_o,
  input  logic         end_init_i,
  input  logic         end_associated_i,
  input  logic         end_cipher_i,
  input  logic         end_i,
  input  logic         cipher_valid_i,
  input  logic [127:0] cipher_i,
  input  logic [127:0] tag_i
);

  localparam int CW = $clog2(NB_PT) + 1;

  typedef enum logic [3:0] {
    IDLE, START, W_INIT, S_AD, W_AD, W_PT, S_PT, W_CT, DONE, ERR
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   blk_cnt;
  logic [127:0]    ad_q;
  logic            accept;
  logic            last_blk;

  assign accept   = go_i && (state == IDLE || state == ERR);
  assign last_blk = (blk_cnt == CW'(NB_PT - 1));

`ifdef ASCON_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_wait;
  assign tmo_wait = (state == W_INIT) || (state == W_AD) || (state == W_CT);
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_o      = 1'b0;
    data_valid_o = 1'b0;
    pt_ready_o   = 1'b0;
    done_o       = 1'b0;
    tag_valid_o  = 1'b0;
    busy_o       = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (go_i) state_nxt = START;
      end
      START: begin
        start_o   = 1'b1;
        state_nxt = W_INIT;
      end
      W_INIT: if (end_init_i) state_nxt = S_AD;
      S_AD: begin
        data_valid_o = 1'b1;
        state_nxt    = W_AD;
      end
      W_AD: if (end_associated_i) state_nxt = W_PT;
      W_PT: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) state_nxt = S_PT;
      end
      S_PT: begin
        data_valid_o = 1'b1;
        state_nxt    = W_CT;
      end
      W_CT: begin
        // The last block completes only on end_i; end_cipher_i alone is not enough.
        if (last_blk) begin
          if (end_i) state_nxt = DONE;
        end else if (end_cipher_i) begin
          state_nxt = W_PT;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        tag_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      ERR: begin
        busy_o = 1'b0;
        if (go_i) state_nxt = START;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef ASCON_HOST_TIMEOUT_EN
    if (tmo_wait && tmo_cnt == '0 && state_nxt == state) state_nxt = ERR;
`endif
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      key_o      <= '0;
      nonce_o    <= '0;
      ad_q       <= '0;
      data_o     <= '0;
      ct_o       <= '0;
      tag_o      <= '0;
      ct_valid_o <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      ct_valid_o <= 1'b0;
      if (accept) begin
        key_o   <= key_i;
        nonce_o <= nonce_i;
        ad_q    <= ad_i;
        tag_o   <= '0;
        blk_cnt <= '0;
      end
      if (state == W_INIT && end_init_i) data_o <= ad_q;
      if (state == W_PT && pt_valid_i)   data_o <= pt_i;
      if (state == W_CT) begin
        // cipher_valid_i is not qualified here: the block is captured on the end flag regardless.
        if (last_blk) begin
          if (end_i) begin
            ct_o       <= cipher_i;
            tag_o      <= tag_i;
            ct_valid_o <= 1'b1;
          end
        end else if (end_cipher_i) begin
          ct_o       <= cipher_i;
          ct_valid_o <= 1'b1;
          blk_cnt    <= blk_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ASCON_HOST_TIMEOUT_EN
  // Down-counter reloaded on every state change; expiry is the zero compare above.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt <= '0;
      error_o <= 1'b0;
    end else begin
      if (state_nxt != state)             tmo_cnt <= TW'(TIMEOUT - 1);
      else if (tmo_wait && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (accept)                                  error_o <= 1'b0;
      else if (state_nxt == ERR && state != ERR)   error_o <= 1'b1;
    end
  end
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_host_ctrl.sv
module tb_ascon_host_ctrl;
  localparam int NB_PT = 3;

  logic         clock_i, reset_i, go_i, pt_valid_i;
  logic [127:0] key_i, nonce_i, ad_i, pt_i;
  logic         pt_ready_o, ct_valid_o, tag_valid_o, busy_o, done_o, error_o, start_o, data_valid_o;
  logic [127:0] ct_o, tag_o, key_o, nonce_o, data_o;
  logic         end_init_i, end_associated_i, end_cipher_i, end_i, cipher_valid_i;
  logic [127:0] cipher_i, tag_i;

  ascon_host_ctrl #(.NB_PT(NB_PT), .TIMEOUT(64)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .go_i(go_i),
    .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i),
    .pt_valid_i(pt_valid_i), .pt_i(pt_i), .pt_ready_o(pt_ready_o),
    .ct_valid_o(ct_valid_o), .ct_o(ct_o), .tag_valid_o(tag_valid_o), .tag_o(tag_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .start_o(start_o),
    .key_o(key_o), .nonce_o(nonce_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .end_init_i(end_init_i), .end_associated_i(end_associated_i),
    .end_cipher_i(end_cipher_i), .end_i(end_i), .cipher_valid_i(cipher_valid_i),
    .cipher_i(cipher_i), .tag_i(tag_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int checks = 0;
  int passed = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void fail_now(string name);
    checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  logic [127:0] exp_data[$];
  logic [127:0] exp_ct[$];
  logic [127:0] exp_tag[$];
  int start_cnt = 0, done_cnt = 0, ct_cnt = 0;

  // Stub core: each flag fires 5 cycles after its stimulus.
  int           stub_cnt = 0, stub_kind = 0, stub_blk = 0;
  bit           no_init = 0, split_last = 0, end_i_seen = 0;
  logic [127:0] stub_data;

  always @(negedge clock_i) begin
    end_init_i = 0; end_associated_i = 0; end_cipher_i = 0; end_i = 0; cipher_valid_i = 0;
    if (reset_i) begin
      stub_cnt = 0; stub_kind = 0; stub_blk = 0;
    end else begin
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          case (stub_kind)
            1: end_init_i = 1;
            2: end_associated_i = 1;
            3: begin end_cipher_i = 1; cipher_valid_i = 1; cipher_i = ~stub_data; end
            4: begin
              end_i = 1; cipher_valid_i = 1; cipher_i = ~stub_data;
              tag_i = key_o ^ nonce_o; end_i_seen = 1;
            end
            5: begin
              end_cipher_i = 1; cipher_valid_i = 1; cipher_i = ~stub_data;
              stub_cnt = 5; stub_kind = 6;
            end
            6: begin
              end_i = 1; cipher_valid_i = 1; cipher_i = ~stub_data;
              tag_i = key_o ^ nonce_o; end_i_seen = 1;
            end
            default: ;
          endcase
        end
      end
      if (start_o) begin
        stub_blk = 0; end_i_seen = 0;
        if (!no_init) begin stub_cnt = 5; stub_kind = 1; end
      end
      if (data_valid_o) begin
        stub_data = data_o;
        stub_cnt  = 5;
        if (stub_blk == 0)          stub_kind = 2;
        else if (stub_blk == NB_PT) stub_kind = split_last ? 5 : 4;
        else                        stub_kind = 3;
        stub_blk++;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (start_o) start_cnt++;
      if (data_valid_o) begin
        if (exp_data.size() == 0) fail_now("data_unexpected");
        else check("data_o", data_o, exp_data.pop_front());
      end
      if (ct_valid_o) begin
        ct_cnt++;
        if (exp_ct.size() == 0) fail_now("ct_unexpected");
        else check("ct_o", ct_o, exp_ct.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        check("tag_valid_with_done", 128'(tag_valid_o), 128'd1);
        check("done_after_end_i", 128'(end_i_seen), 128'd1);
        if (exp_tag.size() == 0) fail_now("tag_unexpected");
        else check("tag_o", tag_o, exp_tag.pop_front());
      end else if (tag_valid_o) begin
        fail_now("tag_valid_without_done");
      end
    end
  end

  logic [127:0] pt_v[3];
  logic [127:0] ct_v[3];

  task automatic send_go(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                         input logic [127:0] t);
    exp_data.push_back(a);
    exp_tag.push_back(t);
    @(negedge clock_i);
    go_i = 1; key_i = k; nonce_i = n; ad_i = a;
    @(negedge clock_i);
    go_i = 0;
  endtask

  task automatic feed_pt(input logic [127:0] pt, input logic [127:0] ct);
    int n = 0;
    while (!pt_ready_o && n < 500) begin @(negedge clock_i); n++; end
    if (n >= 500) fail_now("pt_ready_timeout");
    else begin
      pt_valid_i = 1; pt_i = pt;
      exp_data.push_back(pt);
      exp_ct.push_back(ct);
      @(negedge clock_i);
      pt_valid_i = 0;
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin @(negedge clock_i); n++; end
    if (n >= 500) fail_now("done_timeout");
  endtask

  task automatic feed_all();
    for (int i = 0; i < 3; i++) feed_pt(pt_v[i], ct_v[i]);
  endtask

  task automatic flush();
    exp_data.delete(); exp_ct.delete(); exp_tag.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 128'({busy_o, pt_ready_o, ct_valid_o, tag_valid_o, done_o,
                                error_o, start_o, data_valid_o}), 128'd0);
    check({name, "_data"}, key_o | nonce_o | data_o | ct_o | tag_o, 128'd0);
  endtask

  localparam logic [127:0] K1 = 128'h691AED630E81901F6CB10AD9CA912F80;
  localparam logic [127:0] N1 = 128'h46487B3E06D9D7A80C4C36A20853217C;
  localparam logic [127:0] A1 = 128'h00000001626F42206F74206563696C41;
  localparam logic [127:0] T1 = 128'h2F52965D085847B760FD3C7BC2C20EFC;
  localparam logic [127:0] K2 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] N2 = 128'hF0E0D0C0B0A090807060504030201000;
  localparam logic [127:0] A2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

  task automatic load_vec1();
    pt_v[0] = 128'h00112233445566778899AABBCCDDEEFF; ct_v[0] = 128'hFFEEDDCCBBAA99887766554433221100;
    pt_v[1] = 128'h00000000000000000000000000000000; ct_v[1] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
    pt_v[2] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF; ct_v[2] = 128'h00000000000000000000000000000000;
  endtask

  task automatic load_vec2();
    pt_v[0] = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5; ct_v[0] = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
    pt_v[1] = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F; ct_v[1] = 128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0;
    pt_v[2] = 128'h80000000000000000000000000000001; ct_v[2] = 128'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0, d0, c0, stall_bad;
    reset_i = 0; go_i = 0; pt_valid_i = 0;
    key_i = '0; nonce_i = '0; ad_i = '0; pt_i = '0;
    #1 reset_i = 1;
    repeat (3) @(negedge clock_i);
    check_all_zero("reset");
    reset_i = 0;
    @(negedge clock_i);
    check_all_zero("idle");

    // Directed message with the reference vectors
    load_vec1();
    send_go(K1, N1, A1, T1);
    feed_all();
    wait_done(1);
    check("start_count_1", 128'(start_cnt), 128'd1);
    check("ct_count_1", 128'(ct_cnt), 128'd3);
    check("done_count_1", 128'(done_cnt), 128'd1);
    check("key_o_1", key_o, K1);
    check("nonce_o_1", nonce_o, N1);
    check("error_1", 128'(error_o), 128'd0);

    // Host stalls in W_PT for 200 cycles
    load_vec2();
    send_go(K2, N2, A2, K2 ^ N2);
    begin
      int n = 0;
      while (!pt_ready_o && n < 500) begin @(negedge clock_i); n++; end
      if (n >= 500) fail_now("stall_ready_timeout");
    end
    stall_bad = 0;
    repeat (200) begin
      @(negedge clock_i);
      if (!pt_ready_o || error_o || !busy_o) stall_bad++;
    end
    check("stall_ready_held", 128'(stall_bad), 128'd0);
    feed_all();
    wait_done(2);
    check("done_count_2", 128'(done_cnt), 128'd2);

    // go_i while busy is ignored
    s0 = start_cnt; d0 = done_cnt;
    load_vec1();
    send_go(N1, K1, A2, N1 ^ K1);
    @(negedge clock_i);
    go_i = 1; key_i = 128'hBAD0BAD0BAD0BAD0BAD0BAD0BAD0BAD0;
    @(negedge clock_i);
    go_i = 0;
    feed_pt(pt_v[0], ct_v[0]);
    go_i = 1;
    @(negedge clock_i);
    go_i = 0;
    feed_pt(pt_v[1], ct_v[1]);
    feed_pt(pt_v[2], ct_v[2]);
    wait_done(d0 + 1);
    check("busy_go_key_o", key_o, N1);
    check("busy_go_starts", 128'(start_cnt - s0), 128'd1);
    repeat (3) @(negedge clock_i);
    check("busy_go_idle", 128'(busy_o), 128'd0);

    // Reset in W_CT of block 1
    load_vec2();
    send_go(K2, N2, A1, K2 ^ N2);
    feed_pt(pt_v[0], ct_v[0]);
    feed_pt(pt_v[1], ct_v[1]);
    @(negedge clock_i);
    #2 reset_i = 1;
    #1 check_all_zero("midreset");
    flush();
    @(negedge clock_i);
    reset_i = 0;
    d0 = done_cnt; c0 = ct_cnt;
    load_vec1();
    send_go(K1, N1, A1, T1);
    feed_all();
    wait_done(d0 + 1);
    check("post_reset_ct_count", 128'(ct_cnt - c0), 128'd3);
    check("post_reset_tag", tag_o, T1);

    // Last block: end_cipher_i arrives before end_i
    split_last = 1;
    d0 = done_cnt; c0 = ct_cnt;
    load_vec2();
    send_go(K2, N1, A2, K2 ^ N1);
    feed_all();
    wait_done(d0 + 1);
    check("split_done_count", 128'(done_cnt - d0), 128'd1);
    check("split_ct_count", 128'(ct_cnt - c0), 128'd3);
    split_last = 0;

`ifdef ASCON_HOST_TIMEOUT_EN
    // Watchdog: core never reports end of init
    no_init = 1;
    send_go(K1, N2, A1, K1 ^ N2);
    begin
      int n = 0;
      while (!error_o && n < 200) begin @(negedge clock_i); n++; end
      check("timeout_cycles", 128'(n), 128'd65);
      check("timeout_busy", 128'(busy_o), 128'd0);
    end
    flush();
    no_init = 0;
    d0 = done_cnt;
    load_vec1();
    send_go(K1, N1, A1, T1);
    check("error_cleared", 128'(error_o), 128'd0);
    feed_all();
    wait_done(d0 + 1);
    check("post_error_done", 128'(done_cnt - d0), 128'd1);
`endif

    repeat (5) @(negedge clock_i);
    check("queues_empty", 128'(exp_data.size() + exp_ct.size() + exp_tag.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
